// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage (PC register + instruction memory),
// the fetch queue, and the decode stage.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] instr_in;
    logic            fetch_valid;
    logic            flush;
    logic            pc_write_en;
    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_instr;
    logic [CW-1:0]   count;

    // Fetch/decode side of the bundle.
    modport master (
        output pc_in, instr_in, fetch_valid, flush, dec_ready,
        input  pc_write_en, dec_valid, dec_pc, dec_instr, count
    );

    // Queue side of the bundle.
    modport slave (
        input  pc_in, instr_in, fetch_valid, flush, dec_ready,
        output pc_write_en, dec_valid, dec_pc, dec_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between the PC
// register and decode, with PC stall on full and whole-queue discard on flush.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic empty;
    logic enq;
    logic deq;

    // full/empty come from the registered count only, so no input reaches an output.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign enq = fq.fetch_valid && !full && !fq.flush;
    assign deq = !empty && fq.dec_ready && !fq.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so dec_pc/dec_instr read zero until the first enqueue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (enq) begin
            pc_mem_q[wr_ptr_q]    <= fq.pc_in;
            instr_mem_q[wr_ptr_q] <= fq.instr_in;
        end
    end

    assign fq.pc_write_en = !full;
    assign fq.dec_valid   = !empty;
    assign fq.dec_pc      = pc_mem_q[rd_ptr_q];
    assign fq.dec_instr   = instr_mem_q[rd_ptr_q];
    assign fq.count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue: a queue-based model predicts
// occupancy and dequeue order; a negedge monitor checks every consumed entry.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] cur_pc;
    logic [31:0] cur_instr;
    logic [31:0] flush_target;
    logic [31:0] pc_a, pc_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model-side view of occupancy after the most recent edge.
    task automatic check_state(input string tag);
        check({tag, "_count"},     64'(bus.count),       64'(exp_q.size()));
        check({tag, "_dec_valid"}, 64'(bus.dec_valid),   64'(exp_q.size() != 0));
        check({tag, "_pc_we"},     64'(bus.pc_write_en), 64'(exp_q.size() < DEPTH));
    endtask

    // One clock: drive inputs, let the edge pass, then advance the model.
    task automatic step(input bit fv, input bit fl, input bit rdy, input string tag);
        bit p_enq;
        bus.fetch_valid = fv;
        bus.flush       = fl;
        bus.dec_ready   = rdy;
        bus.pc_in       = cur_pc;
        bus.instr_in    = cur_instr;
        p_enq = fv && !fl && (exp_q.size() < DEPTH);
        @(posedge clk); #1;
        if (fl) begin
            exp_q.delete();
            cur_pc    = flush_target;
            cur_instr = $urandom();
        end else if (p_enq) begin
            exp_q.push_back({cur_pc, cur_instr});
            cur_pc    = cur_pc + 32'd4;
            cur_instr = $urandom();
        end
        check_state(tag);
    endtask

    // Monitor: every handshake that consumes an entry must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst && bus.dec_valid && bus.dec_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                check("deq_unexpected", 64'(bus.dec_valid), 64'd0);
            end else begin
                check("deq_pair", {bus.dec_pc, bus.dec_instr}, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.fetch_valid = 1'b1;
        bus.flush       = 1'b0;
        bus.dec_ready   = 1'b0;
        bus.pc_in       = '0;
        bus.instr_in    = 32'h0000_0013;
        cur_pc          = 32'h0;
        cur_instr       = 32'h0000_0013;
        flush_target    = 32'h200;

        // Held in reset with fetch_valid high.
        repeat (2) @(posedge clk);
        #1;
        check("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        check("rst_count",     64'(bus.count),     64'd0);
        check("rst_pc_we",     64'(bus.pc_write_en), 64'd1);
        check("rst_dec_pc",    64'(bus.dec_pc),    64'd0);
        check("rst_dec_instr", 64'(bus.dec_instr), 64'd0);
        rst = 1'b1;

        step(1, 0, 0, "first");
        check("first_dec_pc",    64'(bus.dec_pc),    64'h0);
        check("first_dec_instr", 64'(bus.dec_instr), 64'h13);

        // Fill to DEPTH, then a held fifth pair.
        repeat (3) step(1, 0, 0, "fill");
        check("fill_count", 64'(bus.count), 64'd4);
        step(1, 0, 0, "held");
        check("held_pc", 64'(cur_pc), 64'h10);
        step(1, 0, 1, "pop_full");
        check("pop_full_head", 64'(bus.dec_pc), 64'h4);
        step(1, 0, 0, "refill");
        check("refill_count", 64'(bus.count), 64'd4);
        repeat (4) step(0, 0, 1, "drain");

        // Streaming across pointer wrap.
        cur_pc = 32'h100;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, "stream");
            check("stream_count", 64'(bus.count), 64'd1);
        end
        step(0, 0, 1, "stream_drain");

        // Flush with 3 entries, enq and deq requested in the same cycle.
        repeat (3) step(1, 0, 0, "pre_flush");
        flush_target = 32'h200;
        step(1, 1, 1, "flush");
        check("flush_count", 64'(bus.count), 64'd0);
        step(1, 0, 0, "post_flush");
        check("post_flush_pc", 64'(bus.dec_pc), 64'h200);
        step(0, 0, 1, "post_flush_drain");

        // Simultaneous enq/deq at count 2.
        pc_a = cur_pc;
        step(1, 0, 0, "sim_a");
        pc_b = cur_pc;
        step(1, 0, 0, "sim_b");
        step(1, 0, 1, "sim_both");
        check("sim_count",   64'(bus.count),  64'd2);
        check("sim_head",    64'(bus.dec_pc), 64'(pc_b));
        repeat (2) step(0, 0, 1, "sim_drain");

        // Asynchronous reset between edges.
        repeat (3) step(1, 0, 0, "pre_arst");
        #3 rst = 1'b0;
        #1;
        check("arst_dec_valid", 64'(bus.dec_valid),   64'd0);
        check("arst_count",     64'(bus.count),       64'd0);
        check("arst_pc_we",     64'(bus.pc_write_en), 64'd1);
        check("arst_dec_pc",    64'(bus.dec_pc),      64'd0);
        exp_q.delete();
        cur_pc    = 32'h0;
        cur_instr = $urandom();
        @(posedge clk); #1;
        rst = 1'b1;
        step(1, 0, 0, "after_arst");
        check("after_arst_pc", 64'(bus.dec_pc), 64'h0);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            flush_target = 32'($urandom_range(0, 16383)) << 2;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 4) < 3), "rand");
        end
        repeat (DEPTH + 1) step(0, 0, 1, "final_drain");
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
